// File: rtl/serial_deser_pkg.sv
// -----------------------------------------------------------------------------
// serial_deser_pkg
//   Shared types and limits for the serial bit deserializer.
//   - deser_state_t   : output-register occupancy (EMPTY = no word held,
//                       HOLD = a complete word is presented downstream)
//   - DESER_MAX_WIDTH : largest supported word width
// -----------------------------------------------------------------------------
package serial_deser_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } deser_state_t;

    localparam int DESER_MAX_WIDTH = 32;

endpackage : serial_deser_pkg

// File: rtl/deser_bit_mux2.sv
// -----------------------------------------------------------------------------
// deser_bit_mux2
//   Single-bit 2:1 multiplexer used as the optional per-bit inverter in front
//   of the deserializer's storage.
//   Ports:
//     d0_i  : selected when sel_i = 0
//     d1_i  : selected when sel_i = 1
//     sel_i : select
//     y_o   : output
// -----------------------------------------------------------------------------
module deser_bit_mux2 (
    input  logic d0_i,
    input  logic d1_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule : deser_bit_mux2

// File: rtl/serial_bit_deserializer.sv
// -----------------------------------------------------------------------------
// serial_bit_deserializer
//   Collects a serial bit stream, LSB first, into WIDTH-bit words. A shift
//   register gathers the word being built while a one-word output register
//   presents the previous word, so word N+1 can be collected while word N
//   waits for down_ready. At full rate one word leaves every WIDTH beats with
//   no bubble.
//
//   Configuration macro: SERIAL_DESER_INVERT_EN
//     defined   : every incoming bit is inverted by a deser_bit_mux2
//                 (sel=up_data, d0=1, d1=0) before storage
//     undefined : bits are stored as received, no mux exists
//   Handshake timing is the same in both builds.
//
//   Ports:
//     clk        : clock, all state on posedge
//     rst        : synchronous active-high reset
//     up_valid   : upstream bit valid
//     up_ready   : block accepts a bit this cycle
//     up_data    : serial bit
//     down_valid : down_data holds a complete word
//     down_ready : consumer takes down_data this cycle
//     down_data  : assembled word, bit k = k-th accepted bit
//     bit_cnt    : bits collected toward the next word
// -----------------------------------------------------------------------------
module serial_bit_deserializer
    import serial_deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic                     up_data,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [WIDTH-1:0]         down_data,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > DESER_MAX_WIDTH) begin : g_bad_width
        $error("serial_bit_deserializer: WIDTH must be in 2..%0d", DESER_MAX_WIDTH);
    end

    deser_state_t      state_q;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  data_q,  data_d;

    logic bit_in;
    logic at_last;
    logic accept;
    logic handoff;
    logic complete;

    // -------------------------------------------------------------------------
    // Optional per-bit inversion ahead of storage
    // -------------------------------------------------------------------------
`ifdef SERIAL_DESER_INVERT_EN
    deser_bit_mux2 u_invert (
        .d0_i  (1'b1),
        .d1_i  (1'b0),
        .sel_i (up_data),
        .y_o   (bit_in)
    );
`else
    assign bit_in = up_data;
`endif

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    assign down_valid = (state_q == HOLD);
    assign down_data  = data_q;
    assign bit_cnt    = cnt_q;

    assign at_last  = (cnt_q == LAST_IDX);

    // Only the completing bit can stall, and only while the held word is still
    // waiting: every earlier bit lands in the shift register, which is
    // independent of the output register. No path from up_valid.
    assign up_ready = !rst && !(at_last && down_valid && !down_ready);

    assign accept   = up_valid && up_ready;
    assign handoff  = down_valid && down_ready;
    assign complete = accept && at_last;

    // -------------------------------------------------------------------------
    // Next-state datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; leaving one
        // unassigned on some path would infer a latch.
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;

        if (accept) begin
            shift_d[cnt_q] = bit_in;
            if (complete) begin
                // The word includes the bit arriving this cycle, so it moves to
                // the output register from the merged value, not from shift_q.
                data_d  = shift_d;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers and occupancy FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the word registers are reset, not just the control flops,
            // because a reset must discard partial and held words and present
            // an all-zero down_data.
            state_q <= EMPTY;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;

            case (state_q)
                EMPTY: if (complete)              state_q <= HOLD;
                HOLD:  if (handoff && !complete)  state_q <= EMPTY;
                default:                          state_q <= EMPTY;
            endcase
        end
    end

endmodule : serial_bit_deserializer

// File: tb/tb_serial_bit_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_deserializer
//   Self-checking bench for serial_bit_deserializer (WIDTH=8). A behavioural
//   model keeps the accepted-but-unpacked bits in a queue and the presented
//   word in a variable; a monitor compares every cycle, and directed scenarios
//   pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_bit_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic          up_data;
    logic          down_valid;
    logic          down_ready;
    logic [W-1:0]  down_data;
    logic [CW-1:0] bit_cnt;

    always #5 clk = ~clk;

    serial_bit_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .bit_cnt    (bit_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stored word for a raw stream word in this build.
    function automatic logic [W-1:0] xform(input logic [W-1:0] w);
`ifdef SERIAL_DESER_INVERT_EN
        return ~w;
`else
        return w;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    bit           m_bits[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           cyc     = 0;
    int           comp_cyc[$];
    logic [W-1:0] comp_word[$];

    always @(posedge clk) begin : model
        logic         rdy, acc, hand;
        logic [W-1:0] word;
        cyc++;
        if (rst) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            rdy  = !(m_bits.size() == W - 1 && m_valid && !down_ready);
            acc  = up_valid && rdy;
            hand = m_valid && down_ready;
            if (acc) begin
                m_bits.push_back(up_data);
                if (m_bits.size() == W) begin
                    word = '0;
                    for (int i = 0; i < W; i++) word[i] = m_bits[i];
                    m_data  = xform(word);
                    m_valid = 1'b1;
                    m_bits.delete();
                    comp_cyc.push_back(cyc);
                    comp_word.push_back(m_data);
                end else if (hand) begin
                    m_valid = 1'b0;
                end
            end else if (hand) begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle compare, after outputs settle and before inputs move.
    always @(posedge clk) begin
        #1;
        check("down_valid", down_valid, m_valid);
        check("down_data", down_data, m_data);
        check("bit_cnt", bit_cnt, m_bits.size());
        check("up_ready", up_ready,
              !rst && !(m_bits.size() == W - 1 && m_valid && !down_ready));
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // -------------------------------------------------------------------------
    int not_ready_seen = 0;
    bit rand_dr        = 1'b0;

    always @(negedge clk) if (rand_dr) down_ready = 1'($urandom_range(1));

    task automatic drive_idle(input int n);
        for (int k = 0; k < n; k++) begin
            up_valid = 1'b0;
            up_data  = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input int gap_pct);
        bit acc;
        int tries;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < gap_pct) drive_idle(1);
            up_valid = 1'b1;
            up_data  = w[i];
            tries    = 0;
            do begin
                #1;
                acc = up_ready;
                if (!up_ready) not_ready_seen++;
                @(negedge clk);
                tries++;
            end while (!acc && tries < 200);
            if (!acc) check("accept_timeout", 32'd0, 32'd1);
        end
        up_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    initial begin
        int base;
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = 1'b0;
        down_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_down_valid", down_valid, 1'b0);
        check("reset_down_data", down_data, 8'h00);
        check("reset_bit_cnt", bit_cnt, 3'd0);
        check("reset_up_ready", up_ready, 1'b0);
        rst = 1'b0;

        // 1: single word, consumer always ready
        down_ready = 1'b1;
        send_bits(8'hA5, 8, 0);
        check("t1_valid", down_valid, 1'b1);
        check("t1_data", down_data, xform(8'hA5));
        check("t1_bit_cnt", bit_cnt, 3'd0);
        drive_idle(1);
        check("t1_drained", down_valid, 1'b0);

        // 2: back-to-back words at full rate
        not_ready_seen = 0;
        base = comp_cyc.size();
        send_bits(8'h3C, 8, 0);
        send_bits(8'hC3, 8, 0);
        check("t2_no_stall", not_ready_seen, 0);
        check("t2_word0", comp_word[base], xform(8'h3C));
        check("t2_word1", comp_word[base+1], xform(8'hC3));
        check("t2_spacing", comp_cyc[base+1] - comp_cyc[base], 8);
        drive_idle(2);

        // 3: backpressure on the completing bit
        down_ready = 1'b0;
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 7, 0);
        up_valid = 1'b1;
        up_data  = 1'b0;
        #1;
        check("t3_stall", up_ready, 1'b0);
        check("t3_hold_data", down_data, xform(8'h11));
        @(negedge clk);
        #1;
        check("t3_stall_again", up_ready, 1'b0);
        check("t3_hold_again", down_data, xform(8'h11));
        @(negedge clk);
        down_ready = 1'b1;
        #1;
        check("t3_release", up_ready, 1'b1);
        @(negedge clk);
        up_valid = 1'b0;
        check("t3_new_valid", down_valid, 1'b1);
        check("t3_new_data", down_data, xform(8'h22));
        drive_idle(2);

        // 4: random upstream gaps, then fully random traffic
        send_bits(8'h5A, 8, 50);
        check("t4_data", down_data, xform(8'h5A));
        check("t4_bit_cnt", bit_cnt, 3'd0);
        rand_dr = 1'b1;
        for (int k = 0; k < 40; k++) send_bits(8'($urandom), 8, 30);
        rand_dr = 1'b0;
        @(negedge clk);
        down_ready = 1'b1;
        drive_idle(2);

        // 5: reset mid-word
        send_bits(8'h0F, 4, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_ready", up_ready, 1'b0);
        @(negedge clk);
        check("t5_rst_valid", down_valid, 1'b0);
        check("t5_rst_cnt", bit_cnt, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        send_bits(8'hFF, 8, 0);
        check("t5_valid", down_valid, 1'b1);
        check("t5_data", down_data, xform(8'hFF));
        drive_idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_bit_deserializer
